sblk_row_dispatch: RTL and testbench
====================================

Name: sblk_row_dispatch

Overview:
- Parametrised front-end for a row of N_ROW superblocks.
- Takes one shared instruction stream with a per-instruction row mask (unicast, multicast or broadcast) and buffers it in per-row instruction FIFOs.
- Issues each row's next instruction only when that row reports idle on status_sblk.
- Distributes a single shared activation stream to requesting rows by round-robin arbitration.

Parameters:
- N_ROW, 3, number of superblock rows served.
- WID_INST, 14, instruction width (TN+TM+TP+LN+LP fields, opaque here).
- WID_ACT, 16, activation element width; the act bus carries 2 elements.
- INST_FIFO_DEPTH, 4, entries per row instruction FIFO (power of 2, ≥2).
- WID_CNT, $clog2(INST_FIFO_DEPTH+1), FIFO occupancy counter width.

Ports:
- clk_l  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_in  input  WID_INST  instruction word.
- inst_row_mask  input  N_ROW  bit r=1 targets row r.
- inst_in_vld  input  1  instruction valid.
- inst_in_rdy  output  1  instruction accepted when vld&rdy.
- inst_data  output  WID_INST*N_ROW  per-row instruction; row r at [r*WID_INST +: WID_INST].
- inst_en  output  N_ROW  one-cycle issue strobe per row.
- status_sblk  input  N_ROW  1 = row busy.
- act_in  input  2*WID_ACT  shared activation word.
- act_in_vld  input  1  activation valid.
- act_in_rdy  output  1  activation accepted when vld&rdy.
- act_data_out  output  2*WID_ACT  registered activation, broadcast to all rows.
- act_data_vld  output  N_ROW  one-hot: row that owns act_data_out this cycle.
- act_data_req  input  N_ROW  level request from row r.
- fifo_cnt  output  WID_CNT*N_ROW  per-row FIFO occupancy.
- all_idle  output  1  all FIFOs empty, all FSMs IDLE, status_sblk==0.

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty, fifo_cnt=0, FSMs IDLE, rr pointer=0.
  - inst_en=0, inst_data=0, act_data_vld=0, act_data_out=0.
  - inst_in_rdy and act_in_rdy follow their combinational equations.
  - Mid-operation reset discards all queued instructions and any in-flight activation.
- inst_in_rdy = AND over r of (!inst_row_mask[r] | !full[r]).
  - Combinational from the mask; an ongoing pop in the same cycle does not free space.
  - On handshake, the word is pushed into every masked FIFO in the same cycle.
  - mask==0 is accepted and dropped.
- Per-row FSM (independent per r):
  - IDLE: if FIFO non-empty and status_sblk[r]==0, pop the FIFO, register inst_data[r] and pulse inst_en[r]=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until status_sblk[r]==1, then go to RUN.
  - RUN: stay until status_sblk[r]==0, then go to IDLE.
  - inst_data[r] holds its value until the next issue.
  - Minimum latency: push at edge t gives inst_en at edge t+1 (FIFO empty, row idle).
  - Back-to-back issue to the same row is therefore at least 3 cycles apart.
- FIFO:
  - Push and pop in the same cycle keep fifo_cnt unchanged.
  - Read and write pointers wrap modulo INST_FIFO_DEPTH.
  - Order is preserved per row.
- Activation path:
  - act_in_rdy = |act_data_req.
  - On handshake, the winner is the first row with req=1 scanning from rr pointer upward, wrapping modulo N_ROW.
  - Next edge: act_data_out<=act_in, act_data_vld<=onehot(winner), rr pointer<=winner+1 mod N_ROW.
  - Without a handshake, act_data_vld<=0 and act_data_out holds its value.
  - One word per cycle maximum; no word is ever lost or duplicated.
- all_idle is combinational; it is 1 immediately after reset when status_sblk==0.

Test Plan:
- Reset, then push inst 0x0A5 mask 3'b111 with status=0 -> cycle+1: inst_en=3'b111, all inst_data=0x0A5, fifo_cnt all 0.
- Row 1 held busy, push 5 words mask 3'b010 (DEPTH=4) -> 4 accepted, inst_in_rdy=0 on the 5th, fifo_cnt[1]=4; release row 1 -> words issued in order, each only after the status 0→1→0 cycle.
- Row 0 full, push mask 3'b101 -> rdy=0 and no write to row 2; mask 3'b100 in the same state -> accepted.
- act_data_req=3'b111, act_in_vld=1 with data 1,2,3,4 on consecutive cycles -> act_data_vld sequence 001,010,100,001 with matching data.
- act_data_req=3'b000 -> act_in_rdy=0, act_data_vld stays 0; req 3'b100 alone -> grant to row 2 even with rr pointer=0.
- Assert rst_n=0 with 3 words queued and row 0 in RUN -> all fifo_cnt=0, FSMs IDLE, inst_en=0, all_idle=1 once status=0.

Source files
------------

// File: rtl/sblk_row_dispatch.sv
// Superblock row front-end: per-row instruction FIFOs with idle-gated issue,
// plus a round-robin distributor for the shared activation stream.
module sblk_row_dispatch #(
  parameter int unsigned N_ROW           = 3,
  parameter int unsigned WID_INST        = 14,
  parameter int unsigned WID_ACT         = 16,
  parameter int unsigned INST_FIFO_DEPTH = 4,
  parameter int unsigned WID_CNT         = $clog2(INST_FIFO_DEPTH + 1)
) (
  input  logic                        clk_l,
  input  logic                        rst_n,
  input  logic [WID_INST-1:0]         inst_in,
  input  logic [N_ROW-1:0]            inst_row_mask,
  input  logic                        inst_in_vld,
  output logic                        inst_in_rdy,
  output logic [WID_INST*N_ROW-1:0]   inst_data,
  output logic [N_ROW-1:0]            inst_en,
  input  logic [N_ROW-1:0]            status_sblk,
  input  logic [2*WID_ACT-1:0]        act_in,
  input  logic                        act_in_vld,
  output logic                        act_in_rdy,
  output logic [2*WID_ACT-1:0]        act_data_out,
  output logic [N_ROW-1:0]            act_data_vld,
  input  logic [N_ROW-1:0]            act_data_req,
  output logic [WID_CNT*N_ROW-1:0]    fifo_cnt,
  output logic                        all_idle
);

  localparam int unsigned WID_PTR = (INST_FIFO_DEPTH > 1) ? $clog2(INST_FIFO_DEPTH) : 1;
  localparam int unsigned WID_RR  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int unsigned WID_AB  = 2 * WID_ACT;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  logic [N_ROW-1:0] full;
  logic [N_ROW-1:0] row_idle;
  logic             inst_hs;

  // Accept only when every targeted row has room; space freed by a same-cycle pop is not counted.
  assign inst_in_rdy = &(~inst_row_mask | ~full);
  assign inst_hs     = inst_in_vld & inst_in_rdy;
  assign all_idle    = (&row_idle) & ~(|status_sblk);

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    logic [WID_INST-1:0] mem_q [INST_FIFO_DEPTH];
    logic [WID_PTR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WID_PTR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WID_CNT-1:0]  cnt_q, cnt_d;
    logic [1:0]          state_q, state_d;
    logic [WID_INST-1:0] data_q, data_d;
    logic                en_q;
    logic                push;
    logic                pop;

    assign push     = inst_hs & inst_row_mask[r];
    assign full[r]  = (cnt_q == WID_CNT'(INST_FIFO_DEPTH));
    assign row_idle[r] = (cnt_q == '0) && (state_q == ST_IDLE);

    assign inst_data[r*WID_INST +: WID_INST] = data_q;
    assign inst_en[r]                        = en_q;
    assign fifo_cnt[r*WID_CNT +: WID_CNT]    = cnt_q;

    // Issue FSM next state: pop only when a word is queued and the row is idle.
    always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((cnt_q != '0) && !status_sblk[r]) begin
            pop     = 1'b1;
            state_d = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (status_sblk[r]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!status_sblk[r]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // FIFO pointer/occupancy update and issued-word capture.
    always_comb begin
      wr_ptr_d = push ? wr_ptr_q + WID_PTR'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + WID_PTR'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + WID_CNT'(1);
        2'b01:   cnt_d = cnt_q - WID_CNT'(1);
        default: cnt_d = cnt_q;
      endcase
      data_d = pop ? mem_q[rd_ptr_q] : data_q;
    end

    // Row state registers.
    always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= ST_IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        data_q   <= '0;
        en_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        data_q   <= data_d;
        en_q     <= pop;
      end
    end

    // FIFO storage; contents are only meaningful below cnt_q so no reset needed.
    always_ff @(posedge clk_l) begin
      if (push) mem_q[wr_ptr_q] <= inst_in;
    end
  end

  // Activation distribution.
  logic [WID_RR-1:0] rr_q, rr_d;
  logic [WID_RR-1:0] winner;
  logic [WID_AB-1:0] act_data_q, act_data_d;
  logic [N_ROW-1:0]  act_vld_q, act_vld_d;
  logic              act_hs;

  // First requesting row at or above the pointer, wrapping modulo N_ROW.
  function automatic logic [WID_RR-1:0] rr_pick(input logic [N_ROW-1:0] req,
                                                input logic [WID_RR-1:0] ptr);
    logic [WID_RR-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_ROW; k++) begin
      idx = (32'(ptr) + k) % N_ROW;
      if (!found && req[idx[WID_RR-1:0]]) begin
        found = 1'b1;
        pick  = WID_RR'(idx);
      end
    end
    return pick;
  endfunction

  assign act_in_rdy   = |act_data_req;
  assign act_hs       = act_in_vld & act_in_rdy;
  assign winner       = rr_pick(act_data_req, rr_q);
  assign act_data_out = act_data_q;
  assign act_data_vld = act_vld_q;

  // Grant, data capture and pointer advance on an activation handshake.
  always_comb begin
    act_data_d = act_data_q;
    act_vld_d  = '0;
    rr_d       = rr_q;
    if (act_hs) begin
      act_data_d = act_in;
      act_vld_d  = N_ROW'(1) << winner;
      rr_d       = (winner == WID_RR'(N_ROW - 1)) ? '0 : winner + WID_RR'(1);
    end
  end

  // Activation registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q <= '0;
      act_vld_q  <= '0;
      rr_q       <= '0;
    end else begin
      act_data_q <= act_data_d;
      act_vld_q  <= act_vld_d;
      rr_q       <= rr_d;
    end
  end

endmodule

// File: tb/tb_sblk_row_dispatch.sv
// Directed bench for sblk_row_dispatch with hand-computed expectations.
module tb_sblk_row_dispatch;

  localparam int unsigned N_ROW    = 3;
  localparam int unsigned WID_INST = 14;
  localparam int unsigned WID_ACT  = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned WID_CNT  = 3;

  logic                      clk_l;
  logic                      rst_n;
  logic [WID_INST-1:0]       inst_in;
  logic [N_ROW-1:0]          inst_row_mask;
  logic                      inst_in_vld;
  logic                      inst_in_rdy;
  logic [WID_INST*N_ROW-1:0] inst_data;
  logic [N_ROW-1:0]          inst_en;
  logic [N_ROW-1:0]          status_sblk;
  logic [2*WID_ACT-1:0]      act_in;
  logic                      act_in_vld;
  logic                      act_in_rdy;
  logic [2*WID_ACT-1:0]      act_data_out;
  logic [N_ROW-1:0]          act_data_vld;
  logic [N_ROW-1:0]          act_data_req;
  logic [WID_CNT*N_ROW-1:0]  fifo_cnt;
  logic                      all_idle;

  int n_checks = 0;
  int n_errors = 0;

  sblk_row_dispatch #(
    .N_ROW(N_ROW), .WID_INST(WID_INST), .WID_ACT(WID_ACT),
    .INST_FIFO_DEPTH(DEPTH), .WID_CNT(WID_CNT)
  ) dut (
    .clk_l(clk_l), .rst_n(rst_n),
    .inst_in(inst_in), .inst_row_mask(inst_row_mask),
    .inst_in_vld(inst_in_vld), .inst_in_rdy(inst_in_rdy),
    .inst_data(inst_data), .inst_en(inst_en), .status_sblk(status_sblk),
    .act_in(act_in), .act_in_vld(act_in_vld), .act_in_rdy(act_in_rdy),
    .act_data_out(act_data_out), .act_data_vld(act_data_vld),
    .act_data_req(act_data_req), .fifo_cnt(fifo_cnt), .all_idle(all_idle)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  function automatic logic [WID_INST-1:0] row_data(input int r);
    return inst_data[r*WID_INST +: WID_INST];
  endfunction

  function automatic logic [WID_CNT-1:0] row_cnt(input int r);
    return fifo_cnt[r*WID_CNT +: WID_CNT];
  endfunction

  initial begin
    rst_n = 1'b0;
    inst_in = '0; inst_row_mask = '0; inst_in_vld = 1'b0;
    status_sblk = '0;
    act_in = '0; act_in_vld = 1'b0; act_data_req = '0;
    repeat (2) @(posedge clk_l);
    #1;
    // Reset state
    check_eq("rst_inst_en", 64'(inst_en), 64'h0);
    check_eq("rst_inst_data", 64'(inst_data), 64'h0);
    check_eq("rst_fifo_cnt", 64'(fifo_cnt), 64'h0);
    check_eq("rst_act_vld", 64'(act_data_vld), 64'h0);
    check_eq("rst_act_data", 64'(act_data_out), 64'h0);
    check_eq("rst_all_idle", 64'(all_idle), 64'h1);
    check_eq("rst_inst_rdy", 64'(inst_in_rdy), 64'h1);
    check_eq("rst_act_rdy", 64'(act_in_rdy), 64'h0);
    rst_n = 1'b1;

    // Broadcast one word, all rows idle
    inst_in = 14'h0A5; inst_row_mask = 3'b111; inst_in_vld = 1'b1;
    #1;
    check_eq("bc_rdy", 64'(inst_in_rdy), 64'h1);
    tick();
    inst_in_vld = 1'b0; inst_row_mask = '0;
    check_eq("bc_cnt_after_push", 64'(fifo_cnt), 64'h49);
    check_eq("bc_en_early", 64'(inst_en), 64'h0);
    check_eq("bc_all_idle_busy", 64'(all_idle), 64'h0);
    tick();
    check_eq("bc_en", 64'(inst_en), 64'h7);
    check_eq("bc_data", 64'(inst_data), 64'({3{14'h0A5}}));
    check_eq("bc_cnt_after_pop", 64'(fifo_cnt), 64'h0);
    tick();
    check_eq("bc_en_pulse", 64'(inst_en), 64'h0);
    check_eq("bc_data_hold", 64'(inst_data), 64'({3{14'h0A5}}));
    status_sblk = 3'b111; tick();
    status_sblk = 3'b000; tick();
    check_eq("bc_back_idle", 64'(all_idle), 64'h1);

    // Row 1 busy: fill to depth, fifth word refused
    status_sblk = 3'b010;
    for (int i = 0; i < 5; i++) begin
      inst_in = 14'(14'h101 + i); inst_row_mask = 3'b010; inst_in_vld = 1'b1;
      #1;
      check_eq($sformatf("fill1_rdy%0d", i), 64'(inst_in_rdy), (i < 4) ? 64'h1 : 64'h0);
      tick();
    end
    inst_in_vld = 1'b0; inst_row_mask = '0;
    check_eq("fill1_cnt", 64'(fifo_cnt), 64'h20);

    // Row 0 full too: mask 101 blocked, mask 100 accepted
    status_sblk = 3'b011;
    for (int i = 0; i < 4; i++) begin
      inst_in = 14'(14'h201 + i); inst_row_mask = 3'b001; inst_in_vld = 1'b1;
      tick();
    end
    inst_in_vld = 1'b0;
    check_eq("fill0_cnt", 64'(fifo_cnt), 64'h24);
    inst_in = 14'h3FF; inst_row_mask = 3'b101; inst_in_vld = 1'b1;
    #1;
    check_eq("blk101_rdy", 64'(inst_in_rdy), 64'h0);
    tick();
    inst_in_vld = 1'b0;
    check_eq("blk101_cnt", 64'(fifo_cnt), 64'h24);
    inst_in = 14'h3C3; inst_row_mask = 3'b100; inst_in_vld = 1'b1;
    #1;
    check_eq("m100_rdy", 64'(inst_in_rdy), 64'h1);
    tick();
    inst_in_vld = 1'b0; inst_row_mask = '0;
    check_eq("m100_cnt", 64'(fifo_cnt), 64'h64);
    tick();
    check_eq("m100_en", 64'(inst_en), 64'h4);
    check_eq("m100_data", 64'(row_data(2)), 64'h3C3);
    check_eq("m100_cnt_pop", 64'(fifo_cnt), 64'h24);
    status_sblk = 3'b111; tick();
    status_sblk = 3'b011; tick();

    // Release row 1: ordered issue, one per busy/idle round trip
    status_sblk = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("ord_en%0d", k), 64'(inst_en), 64'h2);
      check_eq($sformatf("ord_data%0d", k), 64'(row_data(1)), 64'(14'h101 + k));
      check_eq($sformatf("ord_cnt%0d", k), 64'(row_cnt(1)), 64'(3 - k));
      tick();
      check_eq($sformatf("ord_wait%0d", k), 64'(inst_en), 64'h0);
      status_sblk = 3'b011; tick();
      check_eq($sformatf("ord_run%0d", k), 64'(inst_en), 64'h0);
      status_sblk = 3'b001; tick();
      check_eq($sformatf("ord_idle%0d", k), 64'(inst_en), 64'h0);
    end
    check_eq("ord_row0_cnt", 64'(row_cnt(0)), 64'h4);

    // Activation round robin from pointer 0
    act_data_req = 3'b111; act_in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      act_in = 32'(i + 1);
      if (i == 0) begin
        #1;
        check_eq("rr_rdy", 64'(act_in_rdy), 64'h1);
      end
      tick();
      check_eq($sformatf("rr_vld%0d", i), 64'(act_data_vld), 64'(3'b001 << (i % 3)));
      check_eq($sformatf("rr_data%0d", i), 64'(act_data_out), 64'(i + 1));
    end
    act_in_vld = 1'b0;
    tick();
    check_eq("rr_idle_vld", 64'(act_data_vld), 64'h0);
    check_eq("rr_hold_data", 64'(act_data_out), 64'h4);
    act_data_req = '0;

    // Row 0 into RUN with 3 words queued, then reset
    status_sblk = 3'b000;
    tick();
    check_eq("r0_en", 64'(inst_en), 64'h1);
    check_eq("r0_data", 64'(row_data(0)), 64'h201);
    check_eq("r0_cnt", 64'(row_cnt(0)), 64'h3);
    status_sblk = 3'b001;
    tick();
    check_eq("r0_not_idle", 64'(all_idle), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_cnt", 64'(fifo_cnt), 64'h0);
    check_eq("mrst_en", 64'(inst_en), 64'h0);
    check_eq("mrst_data", 64'(inst_data), 64'h0);
    check_eq("mrst_act_data", 64'(act_data_out), 64'h0);
    status_sblk = 3'b000;
    #1;
    check_eq("mrst_all_idle", 64'(all_idle), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_no_issue", 64'(inst_en), 64'h0);

    // No requesters: activation refused
    act_data_req = 3'b000; act_in = 32'h0000DEAD; act_in_vld = 1'b1;
    #1;
    check_eq("noreq_rdy", 64'(act_in_rdy), 64'h0);
    tick();
    check_eq("noreq_vld", 64'(act_data_vld), 64'h0);
    check_eq("noreq_data", 64'(act_data_out), 64'h0);
    // Lone requester above the pointer wins
    act_data_req = 3'b100; act_in = 32'hABCD1234;
    #1;
    check_eq("req2_rdy", 64'(act_in_rdy), 64'h1);
    tick();
    check_eq("req2_vld", 64'(act_data_vld), 64'h4);
    check_eq("req2_data", 64'(act_data_out), 64'hABCD1234);
    act_in_vld = 1'b0; act_data_req = '0;
    tick();
    check_eq("req2_vld_clr", 64'(act_data_vld), 64'h0);

    // FSM back in IDLE with an empty queue: new word issues at once
    inst_in = 14'h155; inst_row_mask = 3'b001; inst_in_vld = 1'b1;
    tick();
    inst_in_vld = 1'b0; inst_row_mask = '0;
    tick();
    check_eq("post_rst_en", 64'(inst_en), 64'h1);
    check_eq("post_rst_data", 64'(row_data(0)), 64'h155);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
